// File: rtl/ram_stream_reader.sv
// Read-side engine for a 1-cycle-latency SRAM: issues credit-limited read bursts and
// delivers the returned words as a valid/ready stream. Optional: RAM_READER_CHECKSUM_EN.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef RAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] csum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_accepted;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
`endif

  logic w_ren;
  logic w_wr;
  logic w_rd;
  logic w_last;

  // A read is only issued when its word is guaranteed a FIFO slot on return, counting
  // the word already travelling through the RAM pipeline.
  assign w_ren  = (r_state == S_RUN) && (r_issued < r_len) &&
                  ((r_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH));
  assign w_wr   = (r_state == S_RUN) && r_inflight;
  assign w_rd   = out_valid && out_ready;
  assign w_last = w_rd && (r_accepted == (r_len - LEN_W'(1)));

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FIN);
  assign ren       = w_ren;
  assign raddr     = r_base + r_issued[ADDR_WIDTH-1:0];
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
`ifdef RAM_READER_CHECKSUM_EN
  assign csum      = r_csum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      // NOTE: the buffer is only a few entries, so it is reset to give a defined out_data
      // after reset; a larger memory would be left unreset and masked instead.
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
`ifdef RAM_READER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every term above reads
      // the pre-edge value, matching the combinational decode of ren/raddr.
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_len      <= len;
            r_issued   <= '0;
            r_accepted <= '0;
            r_state    <= (len == '0) ? S_FIN : S_RUN;
`ifdef RAM_READER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end

        S_RUN: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
          end else begin
            r_inflight <= w_ren;
            if (w_ren) r_issued <= r_issued + LEN_W'(1);
            if (w_wr) begin
              r_mem[r_wr_ptr] <= rdata;
              r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
              r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
              r_accepted <= r_accepted + LEN_W'(1);
`ifdef RAM_READER_CHECKSUM_EN
              r_csum     <= r_csum ^ out_data;
`endif
            end
            unique case ({w_wr, w_rd})
              2'b10:   r_count <= r_count + CNT_W'(1);
              2'b01:   r_count <= r_count - CNT_W'(1);
              default: r_count <= r_count;
            endcase
            if (w_last) r_state <= S_FIN;
          end
        end

        S_FIN: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
